bsr_scan_sequencer: RTL and testbench

//  Autonomous master for the boundary-scan register (BSR) chain. It drives one

---
 rtl/bsr_scan_sequencer.sv | 152 +++++++++++++++
 tb/tb_bsr_scan_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_scan_sequencer.sv
// Autonomous boundary-scan register master: runs one capture -> shift -> update
// cycle on the BSR pins and collects the shifted-out chain contents.
module bsr_scan_sequencer #(
  parameter int CHAIN_LEN = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode_in,
  input  logic [CHAIN_LEN-1:0] wr_data,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 bsr_clk,
  output logic                 bsr_shift,
  output logic                 bsr_update,
  output logic                 bsr_mode,
  output logic                 bsr_tdi,
  input  logic                 bsr_tdo
);

  localparam int SLOT = 2 * CLK_DIV;
  localparam int PW   = $clog2(SLOT);
  localparam int BW   = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [CHAIN_LEN-1:0] wr_q, wr_d;
  logic [CHAIN_LEN-1:0] rd_q, rd_d;
  logic                 mode_q, mode_d;
  logic                 clk_q, clk_d;
  logic                 shift_q, shift_d;
  logic                 update_q, update_d;
  logic                 tdi_q, tdi_d;
  logic                 slot_end;
  logic                 sample;
  logic [CHAIN_LEN:0]   rd_ins;
  logic [CHAIN_LEN-1:0] wr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      mode_q   <= 1'b0;
      clk_q    <= 1'b0;
      shift_q  <= 1'b0;
      update_q <= 1'b0;
      tdi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mode_q   <= mode_d;
      clk_q    <= clk_d;
      shift_q  <= shift_d;
      update_q <= update_d;
      tdi_q    <= tdi_d;
    end
  end

  // Pin outputs are registered from next-state values so bsr_clk never glitches.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    mode_d   = mode_q;
    slot_end = (phase_q == PW'(SLOT - 1));
    sample   = (phase_q == PW'(CLK_DIV - 1));
    rd_ins   = {bsr_tdo, rd_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          wr_d    = wr_data;
          mode_d  = mode_in;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      CAPTURE: begin
        phase_d = slot_end ? '0 : phase_q + PW'(1);
        if (slot_end) state_d = SHIFT;
      end
      SHIFT: begin
        phase_d = slot_end ? '0 : phase_q + PW'(1);
        if (sample) rd_d = rd_ins[CHAIN_LEN:1];
        if (slot_end) begin
          if (bit_q == BW'(CHAIN_LEN - 1)) begin
            state_d = UPDATE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      UPDATE: begin
        phase_d = slot_end ? '0 : phase_q + PW'(1);
        if (slot_end) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        bit_d   = '0;
      end
    endcase

    if (abort && (state_q == CAPTURE || state_q == SHIFT || state_q == UPDATE)) begin
      state_d = IDLE;
      phase_d = '0;
      bit_d   = '0;
    end

    wr_sel   = wr_d >> bit_d;
    clk_d    = ((state_d == CAPTURE) || (state_d == SHIFT)) && (phase_d >= PW'(CLK_DIV));
    shift_d  = (state_d == SHIFT);
    update_d = (state_d == UPDATE);
    tdi_d    = (state_d == SHIFT) && wr_sel[0];
  end

  assign rd_data    = rd_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign bsr_clk    = clk_q;
  assign bsr_shift  = shift_q;
  assign bsr_update = update_q;
  assign bsr_mode   = mode_q;
  assign bsr_tdi    = tdi_q;

endmodule

// File: tb/tb_bsr_scan_sequencer.sv
// Self-checking bench for bsr_scan_sequencer: loopback chain models, vector table,
// random patterns against a queue-based chain model, and abort/reset/start corner cases.
module tb_bsr_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, abort, mode_in;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, bsr_clk, bsr_shift, bsr_update, bsr_mode, bsr_tdi, bsr_tdo;

  logic       s_start, s_abort, s_mode_in;
  logic [0:0] s_wr, s_rd;
  logic       s_busy, s_done, s_clk, s_shift, s_update, s_mode, s_tdi, s_tdo;

  logic       load_en;
  logic [7:0] load_val;
  logic [7:0] cells;
  logic       s_cell;

  int total = 0;
  int bad   = 0;

  int r_done_cnt, r_done_cyc, r_rises, r_upd, r_tdi_bad, r_busy_bad, r_idle_cyc;
  logic [7:0] r_tdi_seq;

  bsr_scan_sequencer #(.CHAIN_LEN(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_in(mode_in),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
    .bsr_clk(bsr_clk), .bsr_shift(bsr_shift), .bsr_update(bsr_update),
    .bsr_mode(bsr_mode), .bsr_tdi(bsr_tdi), .bsr_tdo(bsr_tdo)
  );

  bsr_scan_sequencer #(.CHAIN_LEN(1), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .mode_in(s_mode_in),
    .wr_data(s_wr), .rd_data(s_rd), .busy(s_busy), .done(s_done),
    .bsr_clk(s_clk), .bsr_shift(s_shift), .bsr_update(s_update),
    .bsr_mode(s_mode), .bsr_tdi(s_tdi), .bsr_tdo(s_tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain models: shift toward cell 0 on each rising bsr_clk while shifting.
  always @(posedge bsr_clk or posedge load_en)
    if (load_en) cells <= load_val;
    else if (bsr_shift) cells <= {bsr_tdi, cells[7:1]};
  assign bsr_tdo = cells[0];

  always @(posedge s_clk or posedge load_en)
    if (load_en) s_cell <= 1'b0;
    else if (s_shift) s_cell <= s_tdi;
  assign s_tdo = s_cell;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    load_val = v;
    load_en  = 1'b1;
    #1 load_en = 1'b0;
  endtask

  // Start a scan in cycle 0 and observe cycles 1..60; optional start pulses and abort.
  task automatic applyStimulus(input logic [7:0] wr, input logic mode,
                               input int pulse_a, input int pulse_b, input int abort_at);
    logic pclk, ptdi;
    int   nbits;
    @(negedge clk);
    wr_data = wr; mode_in = mode; start = 1'b1; abort = 1'b0;
    pclk = bsr_clk; ptdi = bsr_tdi; nbits = 0;
    r_done_cnt = 0; r_done_cyc = -1; r_rises = 0; r_upd = 0;
    r_tdi_bad = 0; r_busy_bad = 0; r_idle_cyc = -1; r_tdi_seq = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start   = (c == pulse_a) || (c == pulse_b);
      abort   = (c == abort_at);
      wr_data = 8'($urandom);
      mode_in = 1'($urandom);
      if (bsr_clk && !pclk) begin
        r_rises++;
        if (bsr_shift && nbits < 8) begin
          r_tdi_seq[nbits] = bsr_tdi;
          nbits++;
        end
      end
      if (bsr_tdi !== ptdi && bsr_clk) r_tdi_bad++;
      if (bsr_update) r_upd++;
      if (r_done_cnt == 0 && abort_at == 0 && busy !== 1'b1) r_busy_bad++;
      if (done) begin
        r_done_cnt++;
        r_done_cyc = c;
      end
      if (abort_at != 0 && r_idle_cyc < 0 && c > abort_at && !busy) r_idle_cyc = c;
      pclk = bsr_clk;
      ptdi = bsr_tdi;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  typedef struct {
    logic [7:0] wr;
    logic [7:0] pre;
    logic       mode;
    logic [7:0] exp_rd;
    logic [7:0] exp_cells;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] wr, pre, exp_rd, exp_cells;
    logic       md;
    logic       q[$];
    int         cnt, cyc;

    vecs[0] = '{wr: 8'hA5, pre: 8'h3C, mode: 1'b1, exp_rd: 8'h3C, exp_cells: 8'hA5};
    vecs[1] = '{wr: 8'h00, pre: 8'hFF, mode: 1'b0, exp_rd: 8'hFF, exp_cells: 8'h00};
    vecs[2] = '{wr: 8'hFF, pre: 8'h00, mode: 1'b1, exp_rd: 8'h00, exp_cells: 8'hFF};
    vecs[3] = '{wr: 8'h81, pre: 8'h7E, mode: 1'b0, exp_rd: 8'h7E, exp_cells: 8'h81};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_in = 1'b0; wr_data = '0;
    s_start = 1'b0; s_abort = 1'b0; s_mode_in = 1'b0; s_wr = '0;
    load_en = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {24'd0, busy, done, bsr_clk, bsr_shift, bsr_update, bsr_mode, bsr_tdi, 1'b0}, 32'd0);
    checkOutput("reset_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;

    // Table-driven loopback scans with the default parameters.
    for (int i = 0; i < 4; i++) begin
      preload(vecs[i].pre);
      applyStimulus(vecs[i].wr, vecs[i].mode, 0, 0, 0);
      checkOutput($sformatf("vec%0d_done_cycle", i), r_done_cyc, 41);
      checkOutput($sformatf("vec%0d_done_count", i), r_done_cnt, 1);
      checkOutput($sformatf("vec%0d_rd_data", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_rd});
      checkOutput($sformatf("vec%0d_chain", i), {24'd0, cells}, {24'd0, vecs[i].exp_cells});
      checkOutput($sformatf("vec%0d_bsr_mode", i), {31'd0, bsr_mode}, {31'd0, vecs[i].mode});
      checkOutput($sformatf("vec%0d_clk_rises", i), r_rises, 9);
      checkOutput($sformatf("vec%0d_update_cycles", i), r_upd, 4);
      checkOutput($sformatf("vec%0d_tdi_sequence", i), {24'd0, r_tdi_seq}, {24'd0, vecs[i].wr});
      checkOutput($sformatf("vec%0d_tdi_stable", i), r_tdi_bad, 0);
      checkOutput($sformatf("vec%0d_busy_window", i), r_busy_bad, 0);
    end

    // Random patterns against a queue model of the chain.
    for (int i = 0; i < 6; i++) begin
      wr = 8'($urandom); pre = 8'($urandom); md = 1'($urandom);
      q.delete();
      for (int k = 0; k < 8; k++) q.push_back(pre[k]);
      for (int k = 0; k < 8; k++) begin
        exp_rd[k] = q.pop_front();
        q.push_back(wr[k]);
      end
      for (int k = 0; k < 8; k++) exp_cells[k] = q[k];
      preload(pre);
      applyStimulus(wr, md, 0, 0, 0);
      checkOutput($sformatf("rnd%0d_rd_data", i), {24'd0, rd_data}, {24'd0, exp_rd});
      checkOutput($sformatf("rnd%0d_chain", i), {24'd0, cells}, {24'd0, exp_cells});
      checkOutput($sformatf("rnd%0d_done_cycle", i), r_done_cyc, 41);
      checkOutput($sformatf("rnd%0d_bsr_mode", i), {31'd0, bsr_mode}, {31'd0, md});
    end

    // start pulses while busy are ignored.
    preload(8'h3C);
    applyStimulus(8'hA5, 1'b1, 5, 20, 0);
    checkOutput("busy_start_done_count", r_done_cnt, 1);
    checkOutput("busy_start_done_cycle", r_done_cyc, 41);
    checkOutput("busy_start_rd_data", {24'd0, rd_data}, 32'h3C);

    // Abort in cycle 12, then a fresh scan must complete.
    preload(8'h3C);
    applyStimulus(8'hA5, 1'b1, 0, 0, 12);
    checkOutput("abort_idle_cycle", r_idle_cyc, 13);
    checkOutput("abort_no_done", r_done_cnt, 0);
    checkOutput("abort_no_update", r_upd, 0);
    checkOutput("abort_mode_hold", {31'd0, bsr_mode}, 32'd1);
    preload(8'h5A);
    applyStimulus(8'hC3, 1'b0, 0, 0, 0);
    checkOutput("after_abort_done_cycle", r_done_cyc, 41);
    checkOutput("after_abort_rd_data", {24'd0, rd_data}, 32'h5A);

    // Asynchronous reset in the middle of SHIFT.
    preload(8'h3C);
    @(negedge clk);
    wr_data = 8'hA5; mode_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("pre_reset_in_shift", {31'd0, bsr_shift}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {24'd0, busy, done, bsr_clk, bsr_shift, bsr_update, bsr_mode, bsr_tdi, 1'b0}, 32'd0);
    checkOutput("async_reset_rd_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_reset_idle", {31'd0, busy}, 32'd0);

    // Minimum configuration: one cell, one clk per phase.
    preload(8'h00);
    @(negedge clk);
    s_wr = 1'b1; s_start = 1'b1;
    cnt = 0; cyc = -1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_done) begin
        cnt++;
        cyc = c;
      end
    end
    checkOutput("min_done_cycle", cyc, 7);
    checkOutput("min_done_count", cnt, 1);
    checkOutput("min_rd_data", {31'd0, s_rd}, 32'd0);
    checkOutput("min_chain", {31'd0, s_cell}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
